// File: rtl/sos_cascade_tdm_pkg.sv
// Shared FSM state, tap indices and fixed-point helpers for the TDM biquad cascade.
// Rounding mode of the quantiser is chosen with SOS_ROUND_EN (see sos_mac_q).
package sos_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [2:0] TAP_B0 = 3'd0;
   localparam logic [2:0] TAP_B1 = 3'd1;
   localparam logic [2:0] TAP_B2 = 3'd2;
   localparam logic [2:0] TAP_A1 = 3'd3;
   localparam logic [2:0] TAP_A2 = 3'd4;
   localparam int         NTAP   = 5;

   function automatic int acc_width(input int wi, input int wf, input int guard);
      return 2 * (wi + wf) + guard;
   endfunction

   // Product-domain sum scaled back to Q(wi.wf), before any clamping.
   function automatic logic signed [63:0] quant_raw(input logic signed [63:0] acc,
                                                    input int wf, input logic rnd);
      logic signed [63:0] r_s;
      r_s = acc + (rnd ? (64'sd1 <<< (wf - 1)) : 64'sd0);
      return r_s >>> wf;
   endfunction

   function automatic logic quant_ovf(input logic signed [63:0] acc, input int wi,
                                      input int wf, input logic rnd);
      logic signed [63:0] r_s;
      logic signed [63:0] max_s;
      logic signed [63:0] min_s;
      r_s   = quant_raw(acc, wf, rnd);
      max_s = (64'sd1 <<< (wi + wf - 1)) - 64'sd1;
      min_s = -(64'sd1 <<< (wi + wf - 1));
      return (r_s > max_s) || (r_s < min_s);
   endfunction

   function automatic logic signed [63:0] sat_quant(input logic signed [63:0] acc, input int wi,
                                                    input int wf, input logic rnd);
      logic signed [63:0] r_s;
      logic signed [63:0] max_s;
      logic signed [63:0] min_s;
      r_s   = quant_raw(acc, wf, rnd);
      max_s = (64'sd1 <<< (wi + wf - 1)) - 64'sd1;
      min_s = -(64'sd1 <<< (wi + wf - 1));
      if (r_s > max_s) begin
         return max_s;
      end else if (r_s < min_s) begin
         return min_s;
      end else begin
         return r_s;
      end
   endfunction

endpackage

// File: rtl/sos_cascade_tdm_mac_q.sv
// Shared multiply-accumulate with quantise/saturate of the running sum.
// SOS_ROUND_EN defined: round-half-up; undefined: truncate (floor).
module sos_mac_q
   import sos_pkg::*;
#(
   parameter int WI    = 5,
   parameter int WF    = 11,
   parameter int GUARD = 3
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             CE,
   input  logic             en,
   input  logic             clr,
   input  logic             sub,
   input  logic             last,
   input  logic [WI+WF-1:0] coef,
   input  logic [WI+WF-1:0] operand,
   output logic [WI+WF-1:0] y_q,
   output logic             ovf
);

   localparam int W    = WI + WF;
   localparam int ACCW = acc_width(WI, WF, GUARD);
`ifdef SOS_ROUND_EN
   localparam logic RND = 1'b1;
`else
   localparam logic RND = 1'b0;
`endif

   logic signed [ACCW-1:0] acc_r;
   logic signed [ACCW-1:0] base_s;
   logic signed [ACCW-1:0] prod_ext_s;
   logic signed [ACCW-1:0] acc_sum_s;
   logic signed [2*W-1:0]  prod_s;

   // Product of this tap folded into the running sum, quantised on every cycle.
   always_comb begin
      prod_s     = (2*W)'(signed'(coef)) * (2*W)'(signed'(operand));
      prod_ext_s = ACCW'(prod_s);
      base_s     = clr ? {ACCW{1'b0}} : acc_r;
      acc_sum_s  = sub ? (base_s - prod_ext_s) : (base_s + prod_ext_s);
      y_q        = W'(sat_quant(64'(acc_sum_s), WI, WF, RND));
      ovf        = last & quant_ovf(64'(acc_sum_s), WI, WF, RND);
   end

   // Accumulator register advances only while the FSM is issuing taps.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         acc_r <= {ACCW{1'b0}};
      end else if (CE && en) begin
         acc_r <= acc_sum_s;
      end
   end

endmodule

// File: rtl/sos_cascade_tdm.sv
// Cascade of NSEC direct-form-I biquads on one time-shared MAC, with coefficient RAM.
// Quantiser rounding is selected by SOS_ROUND_EN inside sos_mac_q.
module sos_cascade_tdm
   import sos_pkg::*;
#(
   parameter int NSEC  = 2,
   parameter int WI    = 5,
   parameter int WF    = 11,
   parameter int GUARD = 3
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic                       CE,
   input  logic [WI+WF-1:0]           din,
   input  logic                       din_valid,
   output logic                       din_ready,
   output logic [WI+WF-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   input  logic                       coef_we,
   input  logic [$clog2(5*NSEC)-1:0]  coef_addr,
   input  logic [WI+WF-1:0]           coef_data,
   output logic                       busy,
   output logic [NSEC-1:0]            ovf,
   input  logic                       ovf_clr
);

   localparam int W     = WI + WF;
   localparam int NCOEF = NTAP * NSEC;
   localparam int AW    = $clog2(NCOEF);
   localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam logic [W-1:0] COEF_ONE = W'(64'd1 << WF);

   state_t          state_r;
   logic [SW-1:0]   sec_r;
   logic [2:0]      tap_r;
   logic [W-1:0]    xin_r;
   logic [W-1:0]    dout_r;
   logic            dout_valid_r;
   logic            din_ready_r;
   logic            busy_r;
   logic [NSEC-1:0] ovf_r;
   logic [W-1:0]    coef_mem_r [NCOEF];
   logic [W-1:0]    x1_r [NSEC];
   logic [W-1:0]    x2_r [NSEC];
   logic [W-1:0]    y1_r [NSEC];
   logic [W-1:0]    y2_r [NSEC];

   logic [AW-1:0]   cidx_s;
   logic [W-1:0]    coef_s;
   logic [W-1:0]    opnd_s;
   logic            mac_en_s;
   logic            clr_s;
   logic            sub_s;
   logic            last_s;
   logic            last_sec_s;
   logic [W-1:0]    y_q_s;
   logic            mac_ovf_s;

   // Coefficient and history operand for the tap currently on the MAC.
   always_comb begin
      cidx_s = AW'(int'(sec_r) * NTAP + int'(tap_r));
      coef_s = coef_mem_r[cidx_s];
      case (tap_r)
         TAP_B0:  opnd_s = xin_r;
         TAP_B1:  opnd_s = x1_r[sec_r];
         TAP_B2:  opnd_s = x2_r[sec_r];
         TAP_A1:  opnd_s = y1_r[sec_r];
         TAP_A2:  opnd_s = y2_r[sec_r];
         default: opnd_s = {W{1'b0}};
      endcase
      mac_en_s   = (state_r == MAC);
      clr_s      = (tap_r == TAP_B0);
      sub_s      = (tap_r == TAP_A1) || (tap_r == TAP_A2);
      last_s     = (tap_r == TAP_A2);
      last_sec_s = (sec_r == SW'(NSEC - 1));
   end

   sos_mac_q #(.WI(WI), .WF(WF), .GUARD(GUARD)) u_mac (
      .CLK     (CLK),
      .Reset   (Reset),
      .CE      (CE),
      .en      (mac_en_s),
      .clr     (clr_s),
      .sub     (sub_s),
      .last    (last_s),
      .coef    (coef_s),
      .operand (opnd_s),
      .y_q     (y_q_s),
      .ovf     (mac_ovf_s)
   );

   // Sequencer, coefficient RAM, per-section history and sticky overflow flags.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_r      <= IDLE;
         sec_r        <= {SW{1'b0}};
         tap_r        <= TAP_B0;
         xin_r        <= {W{1'b0}};
         dout_r       <= {W{1'b0}};
         dout_valid_r <= 1'b0;
         din_ready_r  <= 1'b1;
         busy_r       <= 1'b0;
         ovf_r        <= {NSEC{1'b0}};
         for (int i = 0; i < NCOEF; i++) begin
            coef_mem_r[i] <= ((i % NTAP) == 0) ? COEF_ONE : {W{1'b0}};
         end
         for (int k = 0; k < NSEC; k++) begin
            x1_r[k] <= {W{1'b0}};
            x2_r[k] <= {W{1'b0}};
            y1_r[k] <= {W{1'b0}};
            y2_r[k] <= {W{1'b0}};
         end
      end else if (CE) begin
         // A clear is overridden bit-wise by a same-cycle overflow set below.
         if (ovf_clr) begin
            ovf_r <= {NSEC{1'b0}};
         end
         case (state_r)
            IDLE: begin
               if (coef_we && (int'(coef_addr) < NCOEF)) begin
                  coef_mem_r[coef_addr] <= coef_data;
               end
               if (din_valid) begin
                  state_r     <= MAC;
                  sec_r       <= {SW{1'b0}};
                  tap_r       <= TAP_B0;
                  xin_r       <= din;
                  din_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
               end
            end
            MAC: begin
               if (last_s) begin
                  x2_r[sec_r] <= x1_r[sec_r];
                  x1_r[sec_r] <= xin_r;
                  y2_r[sec_r] <= y1_r[sec_r];
                  y1_r[sec_r] <= y_q_s;
                  xin_r       <= y_q_s;
                  tap_r       <= TAP_B0;
                  if (mac_ovf_s) begin
                     ovf_r[sec_r] <= 1'b1;
                  end
                  if (last_sec_s) begin
                     state_r      <= OUT;
                     dout_r       <= y_q_s;
                     dout_valid_r <= 1'b1;
                  end else begin
                     sec_r <= sec_r + SW'(1);
                  end
               end else begin
                  tap_r <= tap_r + 3'd1;
               end
            end
            OUT: begin
               if (dout_ready) begin
                  state_r      <= IDLE;
                  dout_valid_r <= 1'b0;
                  din_ready_r  <= 1'b1;
                  busy_r       <= 1'b0;
               end
            end
            default: begin
               state_r      <= IDLE;
               dout_valid_r <= 1'b0;
               din_ready_r  <= 1'b1;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   assign din_ready  = din_ready_r;
   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;
   assign busy       = busy_r;
   assign ovf        = ovf_r;

endmodule
